fp_issue_scheduler: RTL and testbench
=====================================

FP_ISSUE_SCHEDULER -- requirements
Module: fp_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of local threads requesting FP issue.
REQ-002 SHALL have parameter FP_LATENCY, default 5, cycles from issue to FP writeback.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-thread FP instruction ready.
REQ-006 SHALL have port req_subcycles  input  NUM_REQ x 4  per-thread subcycle count minus one (0..15).
REQ-007 SHALL have port issue_hold  input  1  suppress issue this cycle (bubble).
REQ-008 SHALL have port rollback_en  input  1  squash one thread.
REQ-009 SHALL have port rollback_thread  input  log2(NUM_REQ)  thread being squashed.
REQ-010 SHALL have port grant  output  NUM_REQ  one-hot issue grant, zero when no issue.
REQ-011 SHALL have port issue_valid  output  1  instruction issued into FP stage 1 this cycle.
REQ-012 SHALL have port issue_thread  output  log2(NUM_REQ)  thread of issued instruction.
REQ-013 SHALL have port issue_subcycle  output  4  subcycle index of issued instruction.
REQ-014 SHALL have port int_wb_conflict  output  1  single-cycle integer issue forbidden (shared writeback port).
REQ-015 SHALL have port inflight_count  output  4  valid FP ops in flight.

Function
REQ-016 grant/issue_valid/issue_thread/issue_subcycle SHALL be combinational from current state and inputs; all other state registered.
REQ-017 FSM states: IDLE, SEQ; IDLE->SEQ on issue of subcycle 0 with req_subcycles>0; SEQ->IDLE on issue of last subcycle or rollback of locked thread.
REQ-018 IDLE: winner SHALL be first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-019 IDLE issue of subcycle 0 with req_subcycles=0 SHALL stay IDLE (single-subcycle op).
REQ-020 SEQ: SHALL issue only the locked thread, subcycle = counter, counter +1 per issue; other requests ignored.
REQ-021 SEQ with locked thread's req_valid low SHALL issue nothing and hold counter.
REQ-022 rr_ptr SHALL become (winner+1) mod NUM_REQ when that thread's last subcycle issues; otherwise hold.
REQ-023 issue_hold=1 SHALL force issue_valid=0, grant=0; state, counter, rr_ptr hold.
REQ-024 rollback_en for locked thread (or IDLE winner) SHALL suppress issue that cycle and return to/remain IDLE next cycle; rr_ptr unchanged.
REQ-025 rollback of any other thread SHALL not affect sequencing.
REQ-026 Occupancy: FP_LATENCY-entry shift register of {valid, thread}; entry 0 loads {issue_valid, issue_thread}; shifts every cycle regardless of hold.
REQ-027 rollback_en SHALL clear valid of every occupancy entry tagged rollback_thread, same edge as shift.
REQ-028 int_wb_conflict SHALL equal valid of occupancy entry FP_LATENCY-2 (registered).
REQ-029 inflight_count SHALL equal popcount of occupancy valids (registered, 0..FP_LATENCY).
REQ-030 Counter SHALL not wrap past req_subcycles; 15 is a legal final index.

Reset
REQ-031 reset low SHALL immediately force: FSM IDLE, counter 0, rr_ptr 0, occupancy valids 0, int_wb_conflict 0, inflight_count 0, grant 0, issue_valid 0.
REQ-032 Reset mid-sequence SHALL discard locked thread; first post-reset issue arbitrates from thread 0, subcycle 0.
REQ-033 Reset deassertion SHALL be safe on any edge; no issue in a cycle where reset is low.

Verification
REQ-034 req_valid=4'b1111, all req_subcycles=0, 8 cycles -> grant 0001,0010,0100,1000 repeating; inflight_count saturates at 5.
REQ-035 Thread 2 only, req_subcycles=3 -> issue_subcycle 0,1,2,3 on threads 2 consecutive cycles; thread 1 asserted mid-sequence granted only after.
REQ-036 Thread 1 sequence, rollback_en, rollback_thread=1 at subcycle 2 -> no issue that cycle, IDLE next, occupancy entries of thread 1 cleared, inflight_count drops accordingly.
REQ-037 Single issue at cycle t, FP_LATENCY=5 -> int_wb_conflict high exactly cycle t+4 (register delay incl.), low otherwise.
REQ-038 issue_hold high 2 cycles during subcycle 1 of 4 -> subcycles resume at 1, no skip/duplicate; two bubbles in occupancy.
REQ-039 Reset low mid-sequence (subcycle 2) -> outputs zero immediately; after release arbitration restarts at thread 0, subcycle 0.

Source files
------------

// File: rtl/fp_issue_scheduler.sv
// fp_issue_scheduler
// Issue scheduler that picks one local thread per cycle for the shared FP
// pipeline. A single-subcycle op issues in one cycle. A multi-subcycle op
// locks its thread until the last subcycle has issued. An occupancy shadow
// of the FP pipeline tracks ops in flight. It also flags the cycle in which an
// FP writeback would collide with a single-cycle integer writeback.
module fp_issue_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int FP_LATENCY = 5,
   localparam int TW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*4-1:0] req_subcycles,
   input  logic                 issue_hold,
   input  logic                 rollback_en,
   input  logic [TW-1:0]        rollback_thread,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 issue_valid,
   output logic [TW-1:0]        issue_thread,
   output logic [3:0]           issue_subcycle,
   output logic                 int_wb_conflict,
   output logic [3:0]           inflight_count
);

   typedef enum logic {
      IDLE,
      SEQ
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [3:0]    counter;
   logic [3:0]    counter_n;
   logic [TW-1:0] locked_thread;
   logic [TW-1:0] locked_thread_n;
   logic [TW-1:0] rr_ptr;
   logic [TW-1:0] rr_ptr_n;

   logic          idle_found;
   logic [TW-1:0] idle_winner;
   logic          rb_locked;
   logic          rb_winner;

   logic [3:0]    subs [NUM_REQ];

   logic          occ_valid    [FP_LATENCY];
   logic [TW-1:0] occ_thread   [FP_LATENCY];
   logic          occ_valid_n  [FP_LATENCY];
   logic [TW-1:0] occ_thread_n [FP_LATENCY];
   logic [3:0]    occ_count_n;

   // The ring pointer advances past the thread that just finished its op.
   function automatic logic [TW-1:0] inc_ptr(input logic [TW-1:0] p);
      if (p == TW'(NUM_REQ - 1)) begin
         return '0;
      end
      return p + TW'(1);
   endfunction

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_subs
      assign subs[g] = req_subcycles[g*4 +: 4];
   end

   // Round-robin search for the first requesting thread at or after rr_ptr.
   always_comb begin
      int idx;
      idx         = 0;
      idle_found  = 1'b0;
      idle_winner = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (!idle_found && req_valid[TW'(idx)]) begin
            idle_found  = 1'b1;
            idle_winner = TW'(idx);
         end
      end
   end

   assign rb_locked = rollback_en && (rollback_thread == locked_thread);
   assign rb_winner = rollback_en && (rollback_thread == idle_winner);

   // Issue decision. Issue is suppressed by reset, hold, or a squash of the issuing thread.
   always_comb begin
      issue_valid    = 1'b0;
      issue_thread   = '0;
      issue_subcycle = '0;
      if (reset && !issue_hold) begin
         if (state == IDLE) begin
            if (idle_found && !rb_winner) begin
               issue_valid    = 1'b1;
               issue_thread   = idle_winner;
               issue_subcycle = 4'd0;
            end
         end else begin
            if (req_valid[locked_thread] && !rb_locked) begin
               issue_valid    = 1'b1;
               issue_thread   = locked_thread;
               issue_subcycle = counter;
            end
         end
      end
   end

   // One-hot grant that mirrors the issued thread.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = issue_valid && (issue_thread == TW'(i));
      end
   end

   // Sequencing: lock multi-subcycle ops and release on last subcycle or squash.
   always_comb begin
      state_n         = state;
      counter_n       = counter;
      locked_thread_n = locked_thread;
      rr_ptr_n        = rr_ptr;
      case (state)
         IDLE: begin
            if (issue_valid) begin
               if (subs[issue_thread] != 4'd0) begin
                  state_n         = SEQ;
                  locked_thread_n = issue_thread;
                  counter_n       = 4'd1;
               end else begin
                  rr_ptr_n = inc_ptr(issue_thread);
               end
            end
         end
         SEQ: begin
            if (rb_locked) begin
               state_n   = IDLE;
               counter_n = 4'd0;
            end else if (issue_valid) begin
               if (counter >= subs[locked_thread]) begin
                  state_n   = IDLE;
                  counter_n = 4'd0;
                  rr_ptr_n  = inc_ptr(locked_thread);
               end else begin
                  counter_n = counter + 4'd1;
               end
            end
         end
         default: begin
            state_n   = IDLE;
            counter_n = 4'd0;
         end
      endcase
   end

   // Scheduler state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         counter       <= 4'd0;
         locked_thread <= '0;
         rr_ptr        <= '0;
      end else begin
         state         <= state_n;
         counter       <= counter_n;
         locked_thread <= locked_thread_n;
         rr_ptr        <= rr_ptr_n;
      end
   end

   // Next occupancy: shift in this cycle's issue and drop entries of a squashed thread.
   always_comb begin
      occ_valid_n[0]  = issue_valid;
      occ_thread_n[0] = issue_thread;
      for (int i = 1; i < FP_LATENCY; i++) begin
         occ_valid_n[i]  = occ_valid[i-1];
         occ_thread_n[i] = occ_thread[i-1];
      end
      if (rollback_en) begin
         for (int i = 0; i < FP_LATENCY; i++) begin
            if (occ_thread_n[i] == rollback_thread) begin
               occ_valid_n[i] = 1'b0;
            end
         end
      end
      occ_count_n = 4'd0;
      for (int i = 0; i < FP_LATENCY; i++) begin
         occ_count_n = occ_count_n + 4'(occ_valid_n[i]);
      end
   end

   // Occupancy shadow of the FP pipeline. It shifts every cycle, even while issue is held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_valid      <= '{default: 1'b0};
         occ_thread     <= '{default: '0};
         inflight_count <= 4'd0;
      end else begin
         occ_valid      <= occ_valid_n;
         occ_thread     <= occ_thread_n;
         inflight_count <= occ_count_n;
      end
   end

   assign int_wb_conflict = occ_valid[FP_LATENCY-2];

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// tb_fp_issue_scheduler
// Directed bench for fp_issue_scheduler. Each scenario pushes its expected
// issue stream into a queue. A monitor pops one entry for every issue the
// DUT presents. Registered outputs are compared directly in the stimulus.
module tb_fp_issue_scheduler;

   localparam int NUM_REQ    = 4;
   localparam int FP_LATENCY = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req_valid;
   logic [15:0] req_subcycles;
   logic       issue_hold;
   logic       rollback_en;
   logic [1:0] rollback_thread;
   logic [3:0] grant;
   logic       issue_valid;
   logic [1:0] issue_thread;
   logic [3:0] issue_subcycle;
   logic       int_wb_conflict;
   logic [3:0] inflight_count;

   logic [3:0] subs_tb [NUM_REQ];

   typedef struct packed {
      logic [1:0] thread;
      logic [3:0] sub;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_entry;
   int   n_compared   = 0;
   int   n_mismatched = 0;

   assign req_subcycles = {subs_tb[3], subs_tb[2], subs_tb[1], subs_tb[0]};

   fp_issue_scheduler #(
      .NUM_REQ   (NUM_REQ),
      .FP_LATENCY(FP_LATENCY)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_subcycles  (req_subcycles),
      .issue_hold     (issue_hold),
      .rollback_en    (rollback_en),
      .rollback_thread(rollback_thread),
      .grant          (grant),
      .issue_valid    (issue_valid),
      .issue_thread   (issue_thread),
      .issue_subcycle (issue_subcycle),
      .int_wb_conflict(int_wb_conflict),
      .inflight_count (inflight_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_compared++;
      if (actual != expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic hold,
                                input logic rb_en, input logic [1:0] rb_thread);
      req_valid       = valid;
      issue_hold      = hold;
      rollback_en     = rb_en;
      rollback_thread = rb_thread;
   endtask

   task automatic pushExp(input int thread, input int sub);
      exp_t e;
      e.thread = 2'(thread);
      e.sub    = 4'(sub);
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
      repeat (n) tick();
   endtask

   // Monitor: pops one expectation for every issue and checks grant is idle otherwise.
   always @(negedge clk) begin
      if (issue_valid) begin
         if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_issue: got thread %0d subcycle %0d, required no issue (t=%0t)",
                     issue_thread, issue_subcycle, $time);
         end else begin
            mon_entry = exp_q.pop_front();
            checkOutput("issue_thread", int'(issue_thread), int'(mon_entry.thread));
            checkOutput("issue_subcycle", int'(issue_subcycle), int'(mon_entry.sub));
            checkOutput("grant", int'(grant), 1 << mon_entry.thread);
         end
      end else begin
         checkOutput("grant_idle", int'(grant), 0);
      end
   end

   initial begin
      reset = 1'b0;
      applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < NUM_REQ; i++) subs_tb[i] = 4'd0;
      #2;
      checkOutput("reset_grant", int'(grant), 0);
      checkOutput("reset_issue_valid", int'(issue_valid), 0);
      checkOutput("reset_inflight", int'(inflight_count), 0);
      checkOutput("reset_wb_conflict", int'(int_wb_conflict), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;

      $display("[TB] all threads, single subcycle: round robin and fill");
      for (int i = 0; i < 8; i++) pushExp(i % 4, 0);
      applyStimulus(4'b1111, 1'b0, 1'b0, 2'd0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         checkOutput("inflight_fill", int'(inflight_count), (k < 5) ? k : 5);
      end
      applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
      for (int j = 1; j <= 5; j++) begin
         tick();
         checkOutput("inflight_drain", int'(inflight_count), 5 - j);
      end
      checkOutput("queue_empty_a", exp_q.size(), 0);

      $display("[TB] single issue: writeback conflict timing");
      applyStimulus(4'b0001, 1'b0, 1'b0, 2'd0);
      pushExp(0, 0);
      for (int j = 0; j <= 6; j++) begin
         checkOutput("wb_conflict", int'(int_wb_conflict), (j == 4) ? 1 : 0);
         tick();
         applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
      end
      checkOutput("queue_empty_b", exp_q.size(), 0);

      $display("[TB] thread 2 four subcycles, thread 1 waits");
      subs_tb[2] = 4'd3;
      subs_tb[1] = 4'd0;
      pushExp(2, 0); pushExp(2, 1); pushExp(2, 2); pushExp(2, 3); pushExp(1, 0);
      applyStimulus(4'b0100, 1'b0, 1'b0, 2'd0);
      tick();
      applyStimulus(4'b0110, 1'b0, 1'b0, 2'd0);
      tick(); tick(); tick();
      applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0);
      tick();
      drain(6);
      checkOutput("queue_empty_c", exp_q.size(), 0);

      $display("[TB] rollback of locked thread 1 at subcycle 2");
      subs_tb[1] = 4'd3;
      pushExp(1, 0); pushExp(1, 1);
      applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0);
      tick();
      checkOutput("rb_inflight_1", int'(inflight_count), 1);
      tick();
      checkOutput("rb_inflight_2", int'(inflight_count), 2);
      applyStimulus(4'b0010, 1'b0, 1'b1, 2'd1);
      #1;
      checkOutput("rb_no_issue", int'(issue_valid), 0);
      tick();
      checkOutput("rb_inflight_cleared", int'(inflight_count), 0);
      pushExp(1, 0); pushExp(1, 1); pushExp(1, 2); pushExp(1, 3);
      applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0);
      tick();
      applyStimulus(4'b0010, 1'b0, 1'b1, 2'd3);
      tick();
      checkOutput("rb_other_inflight", int'(inflight_count), 2);
      applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0);
      tick(); tick();
      drain(6);
      checkOutput("queue_empty_d", exp_q.size(), 0);

      $display("[TB] issue hold for two cycles at subcycle 1");
      subs_tb[2] = 4'd3;
      pushExp(2, 0); pushExp(2, 1); pushExp(2, 2); pushExp(2, 3);
      applyStimulus(4'b0100, 1'b0, 1'b0, 2'd0);
      tick();
      checkOutput("hold_inflight_0", int'(inflight_count), 1);
      applyStimulus(4'b0100, 1'b1, 1'b0, 2'd0);
      #1;
      checkOutput("hold_issue_valid", int'(issue_valid), 0);
      tick();
      checkOutput("hold_inflight_1", int'(inflight_count), 1);
      tick();
      checkOutput("hold_inflight_2", int'(inflight_count), 1);
      applyStimulus(4'b0100, 1'b0, 1'b0, 2'd0);
      tick();
      checkOutput("hold_inflight_3", int'(inflight_count), 2);
      tick();
      checkOutput("hold_inflight_4", int'(inflight_count), 3);
      tick();
      checkOutput("hold_inflight_5", int'(inflight_count), 3);
      drain(6);
      checkOutput("queue_empty_e", exp_q.size(), 0);

      $display("[TB] reset in the middle of a thread 3 sequence");
      subs_tb[3] = 4'd3;
      subs_tb[0] = 4'd2;
      pushExp(3, 0); pushExp(3, 1);
      applyStimulus(4'b1001, 1'b0, 1'b0, 2'd0);
      tick(); tick();
      reset = 1'b0;
      #1;
      checkOutput("midrst_grant", int'(grant), 0);
      checkOutput("midrst_issue_valid", int'(issue_valid), 0);
      checkOutput("midrst_inflight", int'(inflight_count), 0);
      checkOutput("midrst_wb_conflict", int'(int_wb_conflict), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      pushExp(0, 0); pushExp(0, 1); pushExp(0, 2);
      tick(); tick(); tick();
      drain(6);
      checkOutput("queue_empty_f", exp_q.size(), 0);

      $display("[TB] sixteen subcycles ending at index 15");
      subs_tb[0] = 4'd15;
      subs_tb[1] = 4'd0;
      for (int s = 0; s < 16; s++) pushExp(0, s);
      applyStimulus(4'b0001, 1'b0, 1'b0, 2'd0);
      repeat (16) tick();
      pushExp(1, 0);
      applyStimulus(4'b0011, 1'b0, 1'b0, 2'd0);
      tick();
      drain(2);

      @(negedge clk);
      #1;
      checkOutput("queue_empty_final", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
